// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with an illegal-opcode / bus-timeout TRAP.
// Define MC_SEQ_PERF_CNT_EN to build the cycle/instret performance counters.
module mc_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        im_req,
  output logic        ir_wr,
  output logic        dm_req,
  output logic        dm_we,
  output logic        pc_wr,
  output logic        pc_src,
  output logic        ru_wr,
  output logic [1:0]  ru_src,
  output logic [2:0]  state,
  output logic [1:0]  trap_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam int unsigned WAIT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT + 32'd1) : 32'd1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 32'd0) ? TIMEOUT - 32'd1 : 32'd0);

  localparam logic [1:0] TC_NONE = 2'b00;
  localparam logic [1:0] TC_ILL  = 2'b01;
  localparam logic [1:0] TC_BUS  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // R/I/LUI/AUIPC sequence identically, as do JAL/JALR.
  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JUMP   = 3'd4,
    C_ILL    = 3'd5
  } cls_t;

  state_t            r_state;
  cls_t              r_cls;
  logic [1:0]        r_trap;
  logic [WAIT_W-1:0] r_wait;

  cls_t w_cls;
  logic w_ready;
  logic w_wait_expired;

  // Opcode classification, consumed only in DECODE.
  always_comb begin
    w_cls = C_ILL;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: w_cls = C_ALU;
      7'b0000011: w_cls = C_LOAD;
      7'b0100011: w_cls = C_STORE;
      7'b1100011: w_cls = C_BRANCH;
      7'b1101111, 7'b1100111: w_cls = C_JUMP;
      default: w_cls = C_ILL;
    endcase
  end

  // Ready arriving on the last allowed cycle beats the timeout.
  assign w_ready        = (r_state == S_MEM) ? dm_ready : im_ready;
  assign w_wait_expired = (TIMEOUT != 32'd0) && !w_ready && (r_wait == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cls   <= C_ALU;
      r_trap  <= TC_NONE;
      r_wait  <= '0;
    end else begin
      r_wait <= '0;
      case (r_state)
        S_FETCH: begin
          if (im_ready) begin
            r_state <= S_DECODE;
          end else if (w_wait_expired) begin
            r_state <= S_TRAP;
            r_trap  <= TC_BUS;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (w_cls == C_ILL) begin
            r_state <= S_TRAP;
            r_trap  <= TC_ILL;
          end else begin
            r_cls   <= w_cls;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_cls)
            C_LOAD, C_STORE: r_state <= S_MEM;
            C_BRANCH:        r_state <= S_FETCH;
            default:         r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dm_ready) begin
            r_state <= (r_cls == C_STORE) ? S_FETCH : S_WB;
          end else if (w_wait_expired) begin
            r_state <= S_TRAP;
            r_trap  <= TC_BUS;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Datapath enables decoded from registered state/class plus handshakes; all gated off in reset.
  always_comb begin
    im_req = 1'b0;
    ir_wr  = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    pc_wr  = 1'b0;
    pc_src = 1'b0;
    ru_wr  = 1'b0;
    ru_src = 2'b00;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          im_req = 1'b1;
          ir_wr  = im_ready;
        end
        S_EXEC: begin
          if (r_cls == C_BRANCH) begin
            pc_wr  = 1'b1;
            pc_src = branch_taken;
          end
        end
        S_MEM: begin
          dm_req = 1'b1;
          dm_we  = (r_cls == C_STORE);
          pc_wr  = dm_ready && (r_cls == C_STORE);
        end
        S_WB: begin
          ru_wr  = 1'b1;
          pc_wr  = 1'b1;
          pc_src = (r_cls == C_JUMP);
          if (r_cls == C_LOAD) begin
            ru_src = 2'b01;
          end else if (r_cls == C_JUMP) begin
            ru_src = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  assign state      = r_state;
  assign trap_cause = r_trap;

`ifdef MC_SEQ_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (pc_wr) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: fixed vector table, per-instruction trace model, random instruction mix.
module tb_mc_sequencer;

  localparam int unsigned TO = 4;

`ifdef MC_SEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'b0;
  logic        branch_taken = 1'b0;
  logic        im_ready = 1'b0;
  logic        dm_ready = 1'b0;
  logic        im_req, ir_wr, dm_req, dm_we, pc_wr, pc_src, ru_wr;
  logic [1:0]  ru_src, trap_cause;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  mc_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .im_ready(im_ready), .dm_ready(dm_ready), .im_req(im_req), .ir_wr(ir_wr),
    .dm_req(dm_req), .dm_we(dm_we), .pc_wr(pc_wr), .pc_src(pc_src), .ru_wr(ru_wr),
    .ru_src(ru_src), .state(state), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // en = {im_req, ir_wr, dm_req, dm_we, pc_wr, pc_src, ru_wr}
  typedef struct packed {
    logic [2:0] st;
    logic [1:0] tc;
    logic [6:0] en;
    logic [1:0] rs;
  } out_t;

  typedef struct packed {
    logic [6:0] opc;
    logic       imr;
    logic       dmr;
    logic       bt;
    out_t       exp;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  int    exp_cyc = 0;
  int    exp_ret = 0;
  string phase = "init";
  vec_t  q[$];
  vec_t  tbl[16];
  logic [6:0] legal_ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic vec_t mk(input logic [6:0] opc, input logic imr, dmr, bt,
                              input logic [2:0] st, input logic [1:0] tc,
                              input logic [6:0] en, input logic [1:0] rs);
    vec_t v;
    v.opc = opc; v.imr = imr; v.dmr = dmr; v.bt = bt;
    v.exp.st = st; v.exp.tc = tc; v.exp.en = en; v.exp.rs = rs;
    return v;
  endfunction

  task automatic check(input string name, input out_t exp, input int ecyc, input int eret);
    out_t act;
    int   e_cyc;
    int   e_ret;
    act.st = state;
    act.tc = trap_cause;
    act.en = {im_req, ir_wr, dm_req, dm_we, pc_wr, pc_src, ru_wr};
    act.rs = ru_src;
    e_cyc = PERF_EN ? ecyc : 0;
    e_ret = PERF_EN ? eret : 0;
    checks++;
    if (act !== exp || cycle_cnt !== 32'(e_cyc) || instret_cnt !== 32'(e_ret)) begin
      errors++;
      $display("FAIL %s: got st=%0d tc=%b en=%b rs=%b cyc=%0d ret=%0d, expected st=%0d tc=%b en=%b rs=%b cyc=%0d ret=%0d",
               name, act.st, act.tc, act.en, act.rs, cycle_cnt, instret_cnt,
               exp.st, exp.tc, exp.en, exp.rs, e_cyc, e_ret);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    opcode = v.opc; im_ready = v.imr; dm_ready = v.dmr; branch_taken = v.bt;
    #1 check(name, v.exp, exp_cyc, exp_ret);
    exp_cyc++;
    if (v.exp.en[2]) exp_ret++;
  endtask

  task automatic run_queue(input int max);
    for (int i = 0; i < q.size() && i < max; i++) apply(q[i], $sformatf("%s[%0d]", phase, i));
    q.delete();
  endtask

  // Asynchronous assert checked before any clock edge; release lands just after a rising edge.
  task automatic do_reset();
    out_t z;
    z = '0;
    @(negedge clk);
    rst_n = 1'b0; im_ready = 1'b1; dm_ready = rb(); branch_taken = rb(); opcode = 7'($urandom);
    exp_cyc = 0; exp_ret = 0;
    #1 check({phase, ":reset"}, z, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic classify(input logic [6:0] opc, output bit legal, output bit ld,
                          output bit sto, output bit br, output bit jmp);
    legal = 1'b1; ld = 1'b0; sto = 1'b0; br = 1'b0; jmp = 1'b0;
    case (opc)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: ;
      7'b0000011: ld = 1'b1;
      7'b0100011: sto = 1'b1;
      7'b1100011: br = 1'b1;
      7'b1101111, 7'b1100111: jmp = 1'b1;
      default: legal = 1'b0;
    endcase
  endtask

  task automatic add_trap(input logic [1:0] tc, input int n);
    for (int k = 0; k < n; k++) q.push_back(mk(7'($urandom), rb(), rb(), rb(), 3'd5, tc, 7'b0, 2'b00));
  endtask

  // A memory wait of w stall cycles; TO consecutive stalls end in a bus-timeout trap.
  task automatic add_wait(input bit mem, input bit sto, input logic [6:0] opc, input logic bt,
                          input int w, output bit ok);
    int         n;
    logic [2:0] st;
    logic [6:0] en;
    st = mem ? 3'd3 : 3'd0;
    en = mem ? {2'b00, 1'b1, sto, 3'b000} : 7'b1000000;
    n  = w;
    ok = 1'b1;
    if (TO != 0 && w >= int'(TO)) begin
      n  = int'(TO);
      ok = 1'b0;
    end
    for (int k = 0; k < n; k++)
      q.push_back(mk(opc, mem ? rb() : 1'b0, mem ? 1'b0 : rb(), bt, st, 2'b00, en, 2'b00));
    if (ok) begin
      if (mem) q.push_back(mk(opc, rb(), 1'b1, bt, st, 2'b00, {2'b00, 1'b1, sto, sto, 2'b00}, 2'b00));
      else     q.push_back(mk(opc, 1'b1, rb(), bt, st, 2'b00, 7'b1100000, 2'b00));
    end
  endtask

  task automatic add_instr(input logic [6:0] opc, input logic bt, input int iw, input int dw,
                           input int ntrap, output bit trapped);
    bit legal, ld, sto, br, jmp, ok;
    classify(opc, legal, ld, sto, br, jmp);
    trapped = 1'b0;
    add_wait(1'b0, 1'b0, opc, bt, iw, ok);
    if (!ok) begin add_trap(2'b10, ntrap); trapped = 1'b1; return; end
    q.push_back(mk(opc, rb(), rb(), bt, 3'd1, 2'b00, 7'b0, 2'b00));
    if (!legal) begin add_trap(2'b01, ntrap); trapped = 1'b1; return; end
    if (br) begin
      q.push_back(mk(opc, rb(), rb(), bt, 3'd2, 2'b00, {4'b0000, 1'b1, bt, 1'b0}, 2'b00));
      return;
    end
    q.push_back(mk(opc, rb(), rb(), bt, 3'd2, 2'b00, 7'b0, 2'b00));
    if (ld || sto) begin
      add_wait(1'b1, sto, opc, bt, dw, ok);
      if (!ok) begin add_trap(2'b10, ntrap); trapped = 1'b1; return; end
      if (sto) return;
    end
    q.push_back(mk(opc, rb(), rb(), bt, 3'd4, 2'b00, {4'b0000, 1'b1, jmp, 1'b1},
                   ld ? 2'b01 : (jmp ? 2'b10 : 2'b00)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    bit tr;
    // ALU (0 wait), LOAD with 3 MEM stalls, STORE (0 wait), straight after reset release
    tbl[0]  = mk(OP_ALU,   1'b1, 1'b0, 1'b1, 3'd0, 2'b00, 7'b1100000, 2'b00);
    tbl[1]  = mk(OP_ALU,   1'b0, 1'b1, 1'b1, 3'd1, 2'b00, 7'b0000000, 2'b00);
    tbl[2]  = mk(OP_ALU,   1'b1, 1'b1, 1'b1, 3'd2, 2'b00, 7'b0000000, 2'b00);
    tbl[3]  = mk(OP_ALU,   1'b0, 1'b1, 1'b1, 3'd4, 2'b00, 7'b0000101, 2'b00);
    tbl[4]  = mk(OP_LOAD,  1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 7'b1100000, 2'b00);
    tbl[5]  = mk(OP_LOAD,  1'b0, 1'b0, 1'b0, 3'd1, 2'b00, 7'b0000000, 2'b00);
    tbl[6]  = mk(OP_LOAD,  1'b1, 1'b1, 1'b0, 3'd2, 2'b00, 7'b0000000, 2'b00);
    tbl[7]  = mk(OP_LOAD,  1'b1, 1'b0, 1'b0, 3'd3, 2'b00, 7'b0010000, 2'b00);
    tbl[8]  = mk(OP_LOAD,  1'b0, 1'b0, 1'b0, 3'd3, 2'b00, 7'b0010000, 2'b00);
    tbl[9]  = mk(OP_LOAD,  1'b1, 1'b0, 1'b0, 3'd3, 2'b00, 7'b0010000, 2'b00);
    tbl[10] = mk(OP_LOAD,  1'b0, 1'b1, 1'b0, 3'd3, 2'b00, 7'b0010000, 2'b00);
    tbl[11] = mk(OP_LOAD,  1'b0, 1'b0, 1'b0, 3'd4, 2'b00, 7'b0000101, 2'b01);
    tbl[12] = mk(OP_STORE, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 7'b1100000, 2'b00);
    tbl[13] = mk(OP_STORE, 1'b0, 1'b0, 1'b1, 3'd1, 2'b00, 7'b0000000, 2'b00);
    tbl[14] = mk(OP_STORE, 1'b0, 1'b0, 1'b1, 3'd2, 2'b00, 7'b0000000, 2'b00);
    tbl[15] = mk(OP_STORE, 1'b0, 1'b1, 1'b0, 3'd3, 2'b00, 7'b0011100, 2'b00);

    do_reset();
    phase = "table";
    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("table[%0d]", i));

    phase = "branch";
    add_instr(OP_BR, 1'b1, 0, 0, 0, tr);
    add_instr(OP_BR, 1'b0, 1, 0, 0, tr);
    run_queue(1000);

    phase = "classes";
    add_instr(7'b1101111, rb(), 0, 0, 0, tr);
    add_instr(7'b1100111, rb(), 2, 0, 0, tr);
    add_instr(7'b0110111, rb(), 0, 0, 0, tr);
    add_instr(7'b0010111, rb(), 1, 0, 0, tr);
    add_instr(7'b0010011, rb(), 0, 0, 0, tr);
    run_queue(1000);

    phase = "wait_edge";
    add_instr(OP_STORE, rb(), int'(TO) - 1, int'(TO) - 1, 0, tr);
    add_instr(OP_LOAD, rb(), 0, int'(TO) - 1, 0, tr);
    run_queue(1000);

    phase = "timeout_mem";
    add_instr(OP_STORE, rb(), 0, int'(TO), 5, tr);
    run_queue(1000);
    do_reset();

    phase = "timeout_fetch";
    add_instr(OP_ALU, rb(), int'(TO), 0, 5, tr);
    run_queue(1000);
    do_reset();

    phase = "illegal";
    add_instr(7'b1111111, rb(), 0, 0, 20, tr);
    run_queue(1000);
    do_reset();

    phase = "reset_mid_mem";
    add_instr(OP_LOAD, rb(), 0, 10, 5, tr);
    run_queue(5);
    do_reset();

    phase = "perf";
    repeat (10) add_instr(OP_ALU, rb(), 0, 0, 0, tr);
    q.push_back(mk(OP_ALU, 1'b0, rb(), rb(), 3'd0, 2'b00, 7'b1000000, 2'b00));
    run_queue(1000);
    do_reset();

    phase = "random";
    for (int n = 0; n < 150; n++) begin
      logic [6:0] opc;
      int         iw;
      int         dw;
      opc = ($urandom_range(0, 11) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
      iw  = ($urandom_range(0, 9) == 0) ? int'(TO) + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      dw  = ($urandom_range(0, 9) == 0) ? int'(TO) + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      add_instr(opc, rb(), iw, dw, int'($urandom_range(1, 4)), tr);
      run_queue(1000);
      if (tr) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum wait cycles for im_ready/dm_ready before bus-timeout trap; 0 disables the timeout.
REQ-002 Port clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port opcode  input  7  Inst[6:0] from instruction register, stable from DECODE until next ir_wr.
REQ-005 Port branch_taken  input  1  BU nextPcsrc result, sampled in EXEC.
REQ-006 Port im_ready / dm_ready  input  1 each  memory completion handshakes.
REQ-007 Port im_req, ir_wr, dm_req, dm_we, pc_wr, pc_src, ru_wr  output  1 each  datapath enables; pc_src 1 = ALU target, 0 = PC+4.
REQ-008 Port ru_src  output  2  RU write source: 00 ALU, 01 DM read data, 10 PC+4.
REQ-009 Port state  output  3  current state encoding; trap_cause  output  2  00 none, 01 illegal opcode, 10 bus timeout.
REQ-010 Port cycle_cnt, instret_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-011 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; all outputs SHALL be decoded from registered state, registered opcode class and inputs.
REQ-012 FETCH: im_req=1; on im_ready=1 -> ir_wr=1 same cycle, next DECODE; else stay.
REQ-013 DECODE (1 cycle): classify opcode: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; legal -> register class, next EXEC; other -> TRAP, trap_cause=01.
REQ-014 EXEC (1 cycle): LOAD/STORE -> MEM; BRANCH -> pc_wr=1, pc_src=branch_taken, next FETCH; all other classes -> WB.
REQ-015 MEM: dm_req=1, dm_we=1 only for STORE; on dm_ready: STORE -> pc_wr=1, pc_src=0, next FETCH; LOAD -> WB.
REQ-016 WB (1 cycle): ru_wr=1, pc_wr=1, next FETCH; ru_src=01 for LOAD, 10 for JAL/JALR, else 00; pc_src=1 for JAL/JALR, else 0.
REQ-017 pc_wr SHALL pulse exactly once per retired instruction; ru_wr never asserts outside WB; dm_we never asserts outside MEM.
REQ-018 Latency from ir_wr to next im_req with 0-wait memory: BRANCH 3 cycles, STORE 4, ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5 (ready in first MEM cycle).
REQ-019 Wait counter SHALL clear on entry to FETCH/MEM, increment each cycle ready=0; when TIMEOUT!=0 and count reaches TIMEOUT with ready still 0 -> TRAP, trap_cause=10; ready asserted in the same cycle the count reaches TIMEOUT wins (no trap).
REQ-020 TRAP: all enables 0, trap_cause held; exit only by reset.
REQ-021 Outputs in states where not listed SHALL be 0; ru_src and pc_src default 00/0.

Reset
REQ-022 rst_n=0 SHALL immediately force state=FETCH, trap_cause=00, wait counter=0, counters=0, and all enables 0 (im_req gated by rst_n), including mid-MEM or mid-TRAP.
REQ-023 First im_req SHALL assert in the first cycle after rst_n deasserts.

Configuration
REQ-024 Macro MC_SEQ_PERF_CNT_EN defined: cycle_cnt increments every clk out of reset (including TRAP), instret_cnt increments on each pc_wr, both wrap 0xFFFFFFFF -> 0.
REQ-025 Macro undefined: counter logic absent, cycle_cnt and instret_cnt tied to 0, all other behaviour identical.

Verification
REQ-026 Reset release, im_ready=1, opcode=0110011 -> states 0,1,2,4,0; ru_wr=1 and ru_src=00 in WB; pc_wr once.
REQ-027 opcode=0000011, dm_ready low 3 MEM cycles then high -> dm_req 4 cycles, dm_we=0, WB with ru_src=01, pc_src=0.
REQ-028 opcode=1100011, branch_taken=1 -> pc_wr=1, pc_src=1 in EXEC, ru_wr never 1, next state FETCH.
REQ-029 opcode=1111111 -> DECODE then TRAP, trap_cause=01, outputs 0 for 20 cycles; rst_n pulse -> FETCH, trap_cause=00.
REQ-030 TIMEOUT=4, opcode=0100011, dm_ready held 0 -> TRAP with trap_cause=10 after 4 MEM cycles; rerun with dm_ready=1 on 4th cycle -> no trap.
REQ-031 With MC_SEQ_PERF_CNT_EN, 10 back-to-back 0110011 at 0 wait -> instret_cnt=10, cycle_cnt=40 plus reset-release offset; without macro both read 0.
